// File: rtl/memory_access_stage.sv
// MEM stage: drives the data-memory req/ack bus, aligns/extends loads, builds store lanes,
// stalls upstream while an access is outstanding, and registers the result into MEM/WB.
module memory_access_stage #(
   parameter int size = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_i,
   input  logic [size-1:0] calculated_result_i,
   input  logic [size-1:0] store_data_i,
   input  logic [11:0]     control_signal_i,
   output logic            stall_o,
   output logic            dmem_req_o,
   output logic            dmem_we_o,
   output logic [size-1:0] dmem_addr_o,
   output logic [size-1:0] dmem_wdata_o,
   output logic [3:0]      dmem_be_o,
   input  logic            dmem_ack_i,
   input  logic [size-1:0] dmem_rdata_i,
   output logic            valid_o,
   output logic [size-1:0] wb_data_o,
   output logic [4:0]      rd_addr_o,
   output logic            reg_we_o,
   output logic            misaligned_o
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;

   logic [0:0]      state;
   logic [size-1:0] lat_addr;
   logic [size-1:0] lat_wdata;
   logic [3:0]      lat_be;
   logic            lat_we;
   logic [11:0]     lat_ctrl;

   logic [1:0]      in_size;
   logic [1:0]      in_a;
   logic            in_mem_op;
   logic            in_mis;
   logic [size-1:0] in_wdata;
   logic [3:0]      in_be;

   assign in_size   = control_signal_i[2:1];
   assign in_a      = calculated_result_i[1:0];
   assign in_mem_op = valid_i & (control_signal_i[5] | control_signal_i[4]);
   // Size code 11 falls into the word case along with 10.
   assign in_mis    = in_mem_op & (((in_size == 2'b01) & in_a[0]) |
                                   (in_size[1] & (in_a != 2'b00)));

   always_comb begin
      in_wdata = store_data_i;
      in_be    = 4'b1111;
      case (in_size)
         2'b00: begin
            in_wdata = {4{store_data_i[7:0]}};
            in_be    = 4'b0001 << in_a;
         end
         2'b01: begin
            in_wdata = {2{store_data_i[15:0]}};
            in_be    = 4'b0011 << in_a;
         end
         default: ;
      endcase
   end

   // In WAIT everything comes from the latched copy; the upstream inputs are ignored.
   logic            in_wait;
   logic [size-1:0] cur_addr;
   logic [11:0]     cur_ctrl;
   logic [1:0]      cur_a;
   logic            access;
   logic            done;
   logic            unused_ctrl;

   assign in_wait     = (state == WAIT);
   assign cur_addr    = in_wait ? lat_addr : calculated_result_i;
   assign cur_ctrl    = in_wait ? lat_ctrl : control_signal_i;
   assign cur_a       = cur_addr[1:0];
   assign unused_ctrl = cur_ctrl[0];

   assign access       = !reset & (in_wait | (in_mem_op & !in_mis));
   assign done         = access & dmem_ack_i;
   assign stall_o      = access & !dmem_ack_i;
   assign dmem_req_o   = access;
   assign dmem_we_o    = in_wait ? lat_we : control_signal_i[4];
   assign dmem_addr_o  = {cur_addr[size-1:2], 2'b00};
   assign dmem_wdata_o = in_wait ? lat_wdata : in_wdata;
   assign dmem_be_o    = in_wait ? lat_be : in_be;

   logic [size-1:0] lane;
   logic [size-1:0] load_val;

   assign lane = dmem_rdata_i >> {cur_a, 3'b000};

   always_comb begin
      load_val = lane;
      case (cur_ctrl[2:1])
         2'b00: load_val = cur_ctrl[3] ? {{(size-8){1'b0}}, lane[7:0]}
                                       : {{(size-8){lane[7]}}, lane[7:0]};
         2'b01: load_val = cur_ctrl[3] ? {{(size-16){1'b0}}, lane[15:0]}
                                       : {{(size-16){lane[15]}}, lane[15:0]};
         default: ;
      endcase
   end

   logic            nxt_valid;
   logic [size-1:0] nxt_wb;
   logic            nxt_we;
   logic            nxt_mis;
   logic            cur_rd_nz;

   assign cur_rd_nz = (cur_ctrl[11:7] != 5'd0);

   always_comb begin
      nxt_valid = 1'b0;
      nxt_wb    = cur_addr;
      nxt_we    = 1'b0;
      nxt_mis   = 1'b0;
      if (done) begin
         nxt_valid = 1'b1;
         if (cur_ctrl[5] & !cur_ctrl[4])
            nxt_wb = load_val;
         nxt_we = cur_ctrl[6] & cur_rd_nz & !cur_ctrl[4];
      end else if (!in_wait & in_mis) begin
         nxt_valid = 1'b1;
         nxt_mis   = 1'b1;
      end else if (!in_wait & valid_i & !in_mem_op) begin
         nxt_valid = 1'b1;
         nxt_we    = cur_ctrl[6] & cur_rd_nz;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         lat_be       <= '0;
         lat_we       <= 1'b0;
         lat_ctrl     <= '0;
         valid_o      <= 1'b0;
         wb_data_o    <= '0;
         rd_addr_o    <= '0;
         reg_we_o     <= 1'b0;
         misaligned_o <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_mem_op & !in_mis & !dmem_ack_i) begin
               state     <= WAIT;
               lat_addr  <= calculated_result_i;
               lat_wdata <= in_wdata;
               lat_be    <= in_be;
               lat_we    <= control_signal_i[4];
               lat_ctrl  <= control_signal_i;
            end
            default: if (dmem_ack_i) state <= IDLE;
         endcase
         valid_o      <= nxt_valid;
         wb_data_o    <= nxt_wb;
         rd_addr_o    <= cur_ctrl[11:7];
         reg_we_o     <= nxt_we;
         misaligned_o <= nxt_mis;
      end
   end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage with hand-computed expected values.
module tb_memory_access_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i;
   logic [31:0] calculated_result_i;
   logic [31:0] store_data_i;
   logic [11:0] control_signal_i;
   logic        stall_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_ack_i;
   logic [31:0] dmem_rdata_i;
   logic        valid_o;
   logic [31:0] wb_data_o;
   logic [4:0]  rd_addr_o;
   logic        reg_we_o;
   logic        misaligned_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   memory_access_stage #(.size(32)) dut (
      .clk(clk), .reset(reset), .valid_i(valid_i),
      .calculated_result_i(calculated_result_i), .store_data_i(store_data_i),
      .control_signal_i(control_signal_i), .stall_o(stall_o),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_ack_i(dmem_ack_i),
      .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o), .wb_data_o(wb_data_o),
      .rd_addr_o(rd_addr_o), .reg_we_o(reg_we_o), .misaligned_o(misaligned_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // {rd, reg_we, mem_read, mem_write, load_unsigned, size, reserved}
   function automatic logic [11:0] ctl(input logic [4:0] rd, input logic we, input logic rd_en,
                                       input logic wr, input logic uns, input logic [1:0] sz);
      return {rd, we, rd_en, wr, uns, sz, 1'b0};
   endfunction

   task automatic apply(input logic v, input logic [31:0] res, input logic [31:0] sd,
                        input logic [11:0] c, input logic ack, input logic [31:0] rdata);
      valid_i             = v;
      calculated_result_i = res;
      store_data_i        = sd;
      control_signal_i    = c;
      dmem_ack_i          = ack;
      dmem_rdata_i        = rdata;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_case(input string tag, input logic [31:0] a, input logic uns,
                            input logic [1:0] sz, input logic [31:0] rdata, input logic [31:0] exp);
      apply(1'b1, a, 32'h0, ctl(5'd9, 1'b1, 1'b1, 1'b0, uns, sz), 1'b1, rdata);
      check({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
      tick;
      check({tag, "_wb"}, wb_data_o, exp);
   endtask

   initial begin
      // Reset with a pending, unacked load on the inputs: no request, no stall.
      reset = 1'b1;
      apply(1'b1, 32'h100, 32'h0, ctl(5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10), 1'b0, 32'h0);
      check("rst_req", {31'd0, dmem_req_o}, 32'd0);
      check("rst_stall", {31'd0, stall_o}, 32'd0);
      tick;
      tick;
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_wb", wb_data_o, 32'd0);
      check("rst_regwe", {31'd0, reg_we_o}, 32'd0);
      reset = 1'b0;

      // Word load, same-cycle ack.
      apply(1'b1, 32'h100, 32'h0, ctl(5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10), 1'b1, 32'hDEADBEEF);
      check("lw_req", {31'd0, dmem_req_o}, 32'd1);
      check("lw_stall", {31'd0, stall_o}, 32'd0);
      check("lw_addr", dmem_addr_o, 32'h100);
      check("lw_we", {31'd0, dmem_we_o}, 32'd0);
      tick;
      check("lw_valid", {31'd0, valid_o}, 32'd1);
      check("lw_wb", wb_data_o, 32'hDEADBEEF);
      check("lw_rd", {27'd0, rd_addr_o}, 32'd5);
      check("lw_regwe", {31'd0, reg_we_o}, 32'd1);

      load_case("lb", 32'h103, 1'b0, 2'b00, 32'h80FF_FFFF, 32'hFFFFFF80);
      load_case("lbu", 32'h103, 1'b1, 2'b00, 32'h80FF_FFFF, 32'h00000080);
      load_case("lhu", 32'h102, 1'b1, 2'b01, 32'h80FF_FFFF, 32'h000080FF);
      load_case("lh", 32'h102, 1'b0, 2'b01, 32'h80FF_FFFF, 32'hFFFF80FF);
      load_case("lw11", 32'h104, 1'b0, 2'b11, 32'h1234_5678, 32'h12345678);

      // Byte and half stores.
      apply(1'b1, 32'h101, 32'h12345678, ctl(5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00), 1'b1, 32'h0);
      check("sb_be", {28'd0, dmem_be_o}, 32'h2);
      check("sb_wdata", dmem_wdata_o, 32'h78787878);
      check("sb_we", {31'd0, dmem_we_o}, 32'd1);
      check("sb_addr", dmem_addr_o, 32'h100);
      tick;
      check("sb_valid", {31'd0, valid_o}, 32'd1);
      check("sb_regwe", {31'd0, reg_we_o}, 32'd0);
      check("sb_wb", wb_data_o, 32'h101);
      apply(1'b1, 32'h102, 32'h12345678, ctl(5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01), 1'b1, 32'h0);
      check("sh_be", {28'd0, dmem_be_o}, 32'hC);
      check("sh_wdata", dmem_wdata_o, 32'h56785678);
      tick;

      // Word store, ack delayed three cycles; inputs change but must be ignored in WAIT.
      apply(1'b1, 32'h200, 32'hAABBCCDD, ctl(5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10), 1'b0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("sw_stall%0d", k), {31'd0, stall_o}, 32'd1);
         check($sformatf("sw_req%0d", k), {31'd0, dmem_req_o}, 32'd1);
         check($sformatf("sw_addr%0d", k), dmem_addr_o, 32'h200);
         check($sformatf("sw_be%0d", k), {28'd0, dmem_be_o}, 32'hF);
         check($sformatf("sw_wdata%0d", k), dmem_wdata_o, 32'hAABBCCDD);
         tick;
         check($sformatf("sw_bubble%0d", k), {31'd0, valid_o}, 32'd0);
         apply(1'b1, 32'h7, 32'h0, ctl(5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10), 1'b0, 32'h0);
      end
      apply(1'b1, 32'h7, 32'h0, ctl(5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10), 1'b1, 32'h0);
      check("sw_ack_stall", {31'd0, stall_o}, 32'd0);
      check("sw_ack_addr", dmem_addr_o, 32'h200);
      check("sw_ack_we", {31'd0, dmem_we_o}, 32'd1);
      tick;
      check("sw_valid", {31'd0, valid_o}, 32'd1);
      check("sw_wb", wb_data_o, 32'h200);
      check("sw_regwe", {31'd0, reg_we_o}, 32'd0);
      apply(1'b0, 32'h0, 32'h0, 12'h0, 1'b0, 32'h0);
      check("sw_idle_req", {31'd0, dmem_req_o}, 32'd0);
      tick;

      // Misaligned word load: suppressed, flagged next cycle.
      apply(1'b1, 32'h102, 32'h0, ctl(5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10), 1'b0, 32'h0);
      check("mis_req", {31'd0, dmem_req_o}, 32'd0);
      check("mis_stall", {31'd0, stall_o}, 32'd0);
      tick;
      check("mis_flag", {31'd0, misaligned_o}, 32'd1);
      check("mis_valid", {31'd0, valid_o}, 32'd1);
      check("mis_regwe", {31'd0, reg_we_o}, 32'd0);
      check("mis_wb", wb_data_o, 32'h102);

      // ALU results: rd=0 never writes, rd=3 does; invalid entry is a bubble.
      apply(1'b1, 32'h7, 32'h0, ctl(5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10), 1'b0, 32'h0);
      tick;
      check("add_rd0_regwe", {31'd0, reg_we_o}, 32'd0);
      check("add_rd0_wb", wb_data_o, 32'h7);
      check("add_rd0_mis", {31'd0, misaligned_o}, 32'd0);
      apply(1'b1, 32'h55, 32'h0, ctl(5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10), 1'b0, 32'h0);
      tick;
      check("add_rd3_regwe", {31'd0, reg_we_o}, 32'd1);
      check("add_rd3_rd", {27'd0, rd_addr_o}, 32'd3);
      check("add_rd3_wb", wb_data_o, 32'h55);
      apply(1'b0, 32'h55, 32'h0, ctl(5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10), 1'b0, 32'h0);
      tick;
      check("inv_valid", {31'd0, valid_o}, 32'd0);
      check("inv_regwe", {31'd0, reg_we_o}, 32'd0);

      // Reset while waiting abandons the access; a late ack is ignored.
      apply(1'b1, 32'h300, 32'h0, ctl(5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10), 1'b0, 32'h0);
      tick;
      check("wr_wait_stall", {31'd0, stall_o}, 32'd1);
      reset = 1'b1;
      #1;
      check("wr_rst_req", {31'd0, dmem_req_o}, 32'd0);
      check("wr_rst_stall", {31'd0, stall_o}, 32'd0);
      tick;
      reset = 1'b0;
      apply(1'b0, 32'h0, 32'h0, 12'h0, 1'b1, 32'h12345678);
      check("wr_valid", {31'd0, valid_o}, 32'd0);
      check("wr_wb", wb_data_o, 32'h0);
      check("wr_rd", {27'd0, rd_addr_o}, 32'd0);
      check("wr_late_req", {31'd0, dmem_req_o}, 32'd0);
      check("wr_late_stall", {31'd0, stall_o}, 32'd0);
      tick;
      check("wr_late_valid", {31'd0, valid_o}, 32'd0);
      check("wr_late_regwe", {31'd0, reg_we_o}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
